loa_arbiter16: RTL and testbench
================================

# loa_arbiter16

Two-requester round-robin arbiter and sequencer for one shared 16-bit lower-part-OR approximate adder (LOA). The block accepts add requests from two independent clients over valid/ready handshakes and grants one request per cycle to the single LOA datapath. It returns the 17-bit approximate sum through one registered response port, tagged with the requester ID, and keeps per-requester transaction counters. It sits between client engines and the approximate adder, so the adder is time-shared rather than duplicated.

## Interface
- LOWER_WIDTH, default 4, number of low bits computed by OR (0..15; 0 = exact addition).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has an operand pair.
- req0_ready_o  output  1  requester 0 pair accepted this cycle.
- req0_a_i, req0_b_i  input  16 each  requester 0 operands.
- req1_valid_i  input  1  requester 1 has an operand pair.
- req1_ready_o  output  1  requester 1 pair accepted this cycle.
- req1_a_i, req1_b_i  input  16 each  requester 1 operands.
- resp_valid_o  output  1  response register holds a result.
- resp_ready_i  input  1  consumer accepts the response.
- resp_id_o  output  1  requester that produced the response.
- resp_sum_o  output  17  approximate sum.
- cnt0_o, cnt1_o  output  16 each  completed-accept count per requester.

## Operation
- LOA function, with L = LOWER_WIDTH:
  - sum[L-1:0] = a[L-1:0] | b[L-1:0].
  - Carry-in to the upper part cin = a[L-1] & b[L-1]; cin = 0 when L = 0.
  - sum[16:L] = a[15:L] + b[15:L] + cin, zero-extended to 17 bits, so the carry-out lands in bit 16.
- Output register is free when resp_valid_o = 0, or when resp_valid_o = 1 and resp_ready_i = 1 (drain and refill in the same cycle).
- Grant happens only when the output register is free. Only one ready_o may be high per cycle. ready_o is combinational from the valid inputs, the last-grant pointer and the free condition.
- Round-robin rule:
  - One valid requester: it wins.
  - Both valid: the requester not granted last time wins.
  - The pointer `last` updates only on an actual grant.
- Two states:
  - EMPTY (resp_valid_o = 0).
  - FULL (resp_valid_o = 1). Stay FULL while resp_ready_i = 0; outputs hold stable.
  - On drain without a new grant, go to EMPTY.
  - On drain with a new grant, stay FULL and load the new result.
- On grant: resp_sum_o <= LOA(a, b) of the winner, resp_id_o <= winner, and the winner's cnt increments by 1, wrapping from FFFF to 0000.
- A requester that is refused keeps valid and operands stable. The block does not require this but never samples unaccepted data.

## Timing
- Latency: a request accepted at edge N appears on resp_* after edge N. Throughput is one result per cycle when resp_ready_i stays high.
- Reset, asynchronous and immediate:
  - resp_valid_o = 0, resp_id_o = 0, resp_sum_o = 0, cnt0_o = cnt1_o = 0.
  - last = 1, so requester 0 wins the first tie.
  - ready_o outputs go low while rst_i is high.
- Reset during FULL discards the held response; no handshake completes on that edge.
- Valid deasserted in the same cycle ready_o would rise: no grant, and `last` and the counts are unchanged.
- No combinational path from resp_ready_i to resp_* outputs. A path from resp_ready_i to req*_ready_o is allowed.

## Test plan
- Reset, then req0 only with 29AF + 7A1B (L=4), resp_ready_i = 1 -> next cycle resp_valid_o = 1, resp_id_o = 0, resp_sum_o = 0A3CF, cnt0_o = 1.
- Both requesters valid for 4 cycles (req0: 8943 + FFFF, req1: 5555 + AAAA), resp_ready_i = 1:
  - Grants go 0, 1, 0, 1.
  - Sums alternate 1893F / 0FFFF.
  - cnt0_o = cnt1_o = 2.
- Backpressure: FULL with resp_ready_i = 0 for 3 cycles while both are valid -> both ready_o low, resp_* stable. Raising resp_ready_i gives drain and refill in one cycle, with the correct round-robin winner.
- Boundary: 0000 + 0001 -> 00001. FFFF + FFFF with L=4 -> lower F, cin = 1, upper FFF + FFF + 1 = 1FFF, result 1FFFF. LOWER_WIDTH = 0 build: 29AF + 7A1B -> 0A3CA (exact).
- Counter wrap: preload by issuing 65536 req1 accepts -> cnt1_o wraps to 0000; cnt0_o stays unchanged.
- Assert rst_i asynchronously mid-stream while FULL -> resp_valid_o drops immediately without a clock edge, counts clear, and the first post-reset tie is granted to req0.

Source files
------------

// File: rtl/loa_arbiter16.sv
// Two-requester round-robin front end for one shared 16-bit lower-part-OR approximate adder.
// One grant per cycle into a single registered response slot; per-requester accept counters.
module loa_arbiter16 #(
  parameter int unsigned LOWER_WIDTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req1_b_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_id_o,
  output logic [16:0] resp_sum_o,
  output logic [15:0] cnt0_o,
  output logic [15:0] cnt1_o
);

  localparam int unsigned CinIdx = (LOWER_WIDTH == 0) ? 0 : LOWER_WIDTH - 1;
  localparam logic [15:0] LowMask = 16'((32'd1 << LOWER_WIDTH) - 32'd1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [16:0] sum_q, sum_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  logic        resp_free;
  logic        grant0, grant1, grant_any;
  logic [15:0] win_a, win_b;

  function automatic logic [16:0] loa(input logic [15:0] a, input logic [15:0] b);
    logic        cin;
    logic [16:0] hi;
    logic [16:0] lo;
    cin = (LOWER_WIDTH == 0) ? 1'b0 : (a[CinIdx] & b[CinIdx]);
    hi  = {1'b0, a >> LOWER_WIDTH} + {1'b0, b >> LOWER_WIDTH} + 17'(cin);
    lo  = {1'b0, (a | b) & LowMask};
    return (hi << LOWER_WIDTH) | lo;
  endfunction

  // The slot is free when empty or draining this cycle; ties go to the requester not granted last.
  always_comb begin
    resp_free = (state_q == StEmpty) || resp_ready_i;
    grant0    = !rst_i && resp_free && req0_valid_i && (!req1_valid_i || last_q);
    grant1    = !rst_i && resp_free && req1_valid_i && (!req0_valid_i || !last_q);
    grant_any = grant0 || grant1;
    win_a     = grant1 ? req1_a_i : req0_a_i;
    win_b     = grant1 ? req1_b_i : req0_b_i;
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    unique case (state_q)
      StEmpty: if (grant_any) state_d = StFull;
      StFull:  if (resp_ready_i && !grant_any) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (grant_any) begin
      id_d   = grant1;
      sum_d  = loa(win_a, win_b);
      last_d = grant1;
      if (grant1) begin
        cnt1_d = cnt1_q + 16'd1;
      end else begin
        cnt0_d = cnt0_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign resp_valid_o = (state_q == StFull);
  assign resp_id_o    = id_q;
  assign resp_sum_o   = sum_q;
  assign cnt0_o       = cnt0_q;
  assign cnt1_o       = cnt1_q;

endmodule

// File: tb/tb_loa_arbiter16.sv
// Bench for loa_arbiter16: directed vector table, corner sequences, and a randomized
// run against a rule-level reference model; a LOWER_WIDTH=0 copy checks exact sums.
module tb_loa_arbiter16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1, rr;
  logic [15:0] a0, b0, a1, b1;

  logic        r0, r1, rv, rid;
  logic [16:0] rsum;
  logic [15:0] c0, c1;

  logic        x_r0, x_r1, x_rv, x_rid;
  logic [16:0] x_rsum;
  logic [15:0] x_c0, x_c1;

  loa_arbiter16 #(.LOWER_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_a_i(a1), .req1_b_i(b1),
    .resp_valid_o(rv), .resp_ready_i(rr), .resp_id_o(rid), .resp_sum_o(rsum),
    .cnt0_o(c0), .cnt1_o(c1)
  );

  loa_arbiter16 #(.LOWER_WIDTH(0)) dut_exact (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(x_r0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(x_r1), .req1_a_i(a1), .req1_b_i(b1),
    .resp_valid_o(x_rv), .resp_ready_i(rr), .resp_id_o(x_rid), .resp_sum_o(x_rsum),
    .cnt0_o(x_c0), .cnt1_o(x_c1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference LOA from the arithmetic definition: OR the low L bits, add the high parts.
  function automatic logic [16:0] loa_ref(input int unsigned a, input int unsigned b,
                                          input int unsigned l);
    int unsigned p, lo, cin, hi;
    p   = 32'd1 << l;
    lo  = (a | b) % p;
    cin = (l == 0) ? 0 : (((a >> (l - 1)) & 1) & ((b >> (l - 1)) & 1));
    hi  = (a / p + b / p + cin) * p;
    return 17'(hi + lo);
  endfunction

  task automatic drive(input logic iv0, input logic [15:0] ia0, input logic [15:0] ib0,
                       input logic iv1, input logic [15:0] ia1, input logic [15:0] ib1,
                       input logic irr);
    v0 = iv0; a0 = ia0; b0 = ib0;
    v1 = iv1; a1 = ia1; b1 = ib1;
    rr = irr;
  endtask

  typedef struct {
    logic        v0;
    logic [15:0] a0, b0;
    logic        v1;
    logic [15:0] a1, b1;
    logic        rr;
    logic        er0, er1, ev, eid;
    logic [16:0] esum, eexact;
    logic [15:0] ec0, ec1;
  } vec_t;

  localparam int NV = 15;
  vec_t tv[NV];

  // Reference model state
  logic        m_valid, m_id, m_last;
  logic [16:0] m_sum, m_exact;
  logic [15:0] m_cnt0, m_cnt1;

  initial begin
    logic g0, g1, free, w;
    logic [15:0] wa, wb;

    tv[0]  = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b0, 17'h1893F, 17'h18942, 16'd1, 16'd0};
    tv[1]  = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b1, 17'h0FFFF, 17'h0FFFF, 16'd1, 16'd1};
    tv[2]  = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b0, 17'h1893F, 17'h18942, 16'd2, 16'd1};
    tv[3]  = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b1, 17'h0FFFF, 17'h0FFFF, 16'd2, 16'd2};
    tv[4]  = '{1'b1, 16'h29AF, 16'h7A1B, 1'b0, 16'h0000, 16'h0000, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b0, 17'h0A3CF, 17'h0A3CA, 16'd3, 16'd2};
    tv[5]  = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0, 17'h0A3CF, 17'h0A3CA, 16'd3, 16'd2};
    tv[6]  = tv[5];
    tv[7]  = tv[5];
    tv[8]  = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b1, 17'h0FFFF, 17'h0FFFF, 16'd3, 16'd3};
    tv[9]  = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1,
               1'b1, 1'b0, 1'b1, 1'b0, 17'h00001, 17'h00001, 16'd4, 16'd3};
    tv[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b1, 17'h1FFFF, 17'h1FFFE, 16'd4, 16'd4};
    tv[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 17'h0, 17'h0, 16'd4, 16'd4};
    tv[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 17'h0, 17'h0, 16'd4, 16'd4};
    tv[13] = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 17'h1893F, 17'h18942, 16'd5, 16'd4};
    tv[14] = '{1'b1, 16'h8943, 16'hFFFF, 1'b1, 16'h5555, 16'hAAAA, 1'b1,
               1'b0, 1'b1, 1'b1, 1'b1, 17'h0FFFF, 17'h0FFFF, 16'd5, 16'd5};

    // Reset with both requesters valid: ready must stay low while rst is high.
    rst = 1'b1;
    drive(1'b1, 16'h1111, 16'h2222, 1'b1, 16'h3333, 16'h4444, 1'b1);
    #1;
    check("rst_ready0", r0, 1'b0);
    check("rst_ready1", r1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", rv, 1'b0);
    check("rst_id", rid, 1'b0);
    check("rst_sum", rsum, 17'h0);
    check("rst_cnt0", c0, 16'h0);
    check("rst_cnt1", c1, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].v0, tv[i].a0, tv[i].b0, tv[i].v1, tv[i].a1, tv[i].b1, tv[i].rr);
      #1;
      check($sformatf("vec%0d_ready0", i), r0, tv[i].er0);
      check($sformatf("vec%0d_ready1", i), r1, tv[i].er1);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), rv, tv[i].ev);
      check($sformatf("vec%0d_cnt0", i), c0, tv[i].ec0);
      check($sformatf("vec%0d_cnt1", i), c1, tv[i].ec1);
      if (tv[i].ev) begin
        check($sformatf("vec%0d_id", i), rid, tv[i].eid);
        check($sformatf("vec%0d_sum", i), rsum, tv[i].esum);
        check($sformatf("vec%0d_exact_sum", i), x_rsum, tv[i].eexact);
      end
    end

    // Counter wrap: one req0 accept, then 65536 req1 accepts.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 16'h0004, 1'b1);
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (i == 65534) check("wrap_cnt1_ffff", c1, 16'hFFFF);
    end
    check("wrap_cnt1_zero", c1, 16'h0000);
    check("wrap_cnt0_hold", c0, 16'h0001);

    // Randomized run against the reference model.
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    rst = 1'b0;
    m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1;
    m_sum = '0; m_exact = '0; m_cnt0 = '0; m_cnt1 = '0;
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 6);
      #1;
      free = !m_valid || rr;
      g0 = free && v0 && (!v1 || m_last);
      g1 = free && v1 && (!v0 || !m_last);
      check("rnd_ready0", r0, g0);
      check("rnd_ready1", r1, g1);
      check("rnd_exact_ready0", x_r0, g0);
      if (g0 || g1) begin
        w  = g1;
        wa = w ? a1 : a0;
        wb = w ? b1 : b0;
        m_valid = 1'b1;
        m_id    = w;
        m_sum   = loa_ref(wa, wb, 4);
        m_exact = 17'(wa) + 17'(wb);
        m_last  = w;
        if (w) m_cnt1 = m_cnt1 + 16'd1;
        else   m_cnt0 = m_cnt0 + 16'd1;
      end else if (rr) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
      check("rnd_valid", rv, m_valid);
      check("rnd_cnt0", c0, m_cnt0);
      check("rnd_cnt1", c1, m_cnt1);
      check("rnd_exact_cnt1", x_c1, m_cnt1);
      if (m_valid) begin
        check("rnd_id", rid, m_id);
        check("rnd_sum", rsum, m_sum);
        check("rnd_exact_sum", x_rsum, m_exact);
        check("rnd_exact_id", x_rid, m_id);
      end
    end

    // Asynchronous reset while FULL, between clock edges.
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 16'h0, 16'h0, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5678, 16'h8765, 1'b0);
    check("pre_async_valid", rv, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", rv, 1'b0);
    check("async_cnt0", c0, 16'h0);
    check("async_cnt1", c1, 16'h0);
    check("async_exact_valid", x_rv, 1'b0);
    check("async_exact_cnt0", x_c0, 16'h0);
    check("async_ready0", r0, 1'b0);
    check("async_ready1", r1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'h29AF, 16'h7A1B, 1'b1, 16'h5555, 16'hAAAA, 1'b1);
    #1;
    check("post_rst_ready0", r0, 1'b1);
    check("post_rst_ready1", r1, 1'b0);
    @(negedge clk);
    check("post_rst_valid", rv, 1'b1);
    check("post_rst_id", rid, 1'b0);
    check("post_rst_sum", rsum, 17'h0A3CF);
    check("post_rst_cnt0", c0, 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
